// File: rtl/usart_pkg.sv
// Shared USART definitions: FSM encodings, frame geometry and bit-period helpers.
// The first four state codes are common to the transmitter and receiver.
package usart_pkg;

    localparam int          USART_DATA_BITS = 8;
    localparam logic [11:0] USART_MIN_CPB   = 12'd4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BIT   = 3'd2,
        STOP_BIT   = 3'd3,
        BREAK_WAIT = 3'd4
    } usart_state_t;

    function automatic logic [11:0] half_wait_end(input logic [11:0] cpb);
        return (cpb >> 1) - 12'd1;
    endfunction

    function automatic logic [11:0] full_wait_end(input logic [11:0] cpb);
        return cpb - 12'd1;
    endfunction

endpackage

// File: rtl/usart_sync.sv
// N-stage synchroniser for an asynchronous serial line; resets to 1 (idle line).
// Latency: STAGES cycles; backpressure: none, free-running.
module usart_sync #(
    parameter int STAGES = 2
) (
    input  logic comm_clock,
    input  logic reset,
    input  logic raw,
    output logic synced
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge comm_clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[STAGES-1];

endmodule

// File: rtl/usart_rx.sv
// 8N1 serial receiver, LSB first, bit period set by clocks_per_bit; byte out via valid/ready.
// Latency: ~9.5 bit periods plus sync delay from start edge; backpressure: unconsumed byte blocks, later frames raise overrun.
module usart_rx
    import usart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        comm_clock,
    input  logic        reset,
    input  logic [11:0] clocks_per_bit,
    input  logic        rx_pin,
    output logic [7:0]  data_out,
    output logic        valid,
    input  logic        ready,
    output logic        busy,
    output logic        framing_error,
    output logic        overrun
);

    logic                   rx_s;
    usart_state_t           state;
    logic [11:0]            cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   armed;
    logic                   half_end;
    logic                   full_end;

    usart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .comm_clock (comm_clock),
        .reset      (reset),
        .raw        (rx_pin),
        .synced     (rx_s)
    );

    assign half_end = (cnt == half_wait_end(clocks_per_bit));
    assign full_end = (cnt == full_wait_end(clocks_per_bit));
    assign busy     = (state != IDLE);

    // prime_q marks when the synchroniser holds a real line sample rather than its reset value
    always_ff @(posedge comm_clock or posedge reset) begin
        if (reset) begin
            prime_q <= '0;
        end else begin
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge comm_clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            data_out      <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            armed         <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    // first real sample after reset: a low line is a break, not a start
                    if (!armed) begin
                        if (prime_q[SYNC_STAGES-1]) begin
                            armed <= 1'b1;
                            if (!rx_s) begin
                                state <= BREAK_WAIT;
                            end
                        end
                    end else if (clocks_per_bit >= USART_MIN_CPB && !rx_s) begin
                        state <= START_BIT;
                    end
                end

                START_BIT: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA_BIT;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end

                DATA_BIT: begin
                    if (full_end) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'(USART_DATA_BITS - 1)) begin
                            state <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end

                STOP_BIT: begin
                    if (full_end) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // a same-edge handshake frees the slot, so the new byte lands
                            if (!valid || ready) begin
                                data_out <= shreg;
                                valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= BREAK_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end

                BREAK_WAIT: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx: framing, glitch rejection, errors, overrun, reset and minimum bit period.
module tb_usart_rx;

    logic        comm_clock;
    logic        reset;
    logic [11:0] clocks_per_bit;
    logic        rx_pin;
    logic [7:0]  data_out;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        framing_error;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int busy_run = 0;
    int busy_max = 0;
    logic valid_q = 1'b0;

    usart_rx #(
        .SYNC_STAGES (2)
    ) dut (
        .comm_clock     (comm_clock),
        .reset          (reset),
        .clocks_per_bit (clocks_per_bit),
        .rx_pin         (rx_pin),
        .data_out       (data_out),
        .valid          (valid),
        .ready          (ready),
        .busy           (busy),
        .framing_error  (framing_error),
        .overrun        (overrun)
    );

    initial begin
        comm_clock = 1'b0;
        forever #5 comm_clock = ~comm_clock;
    end

    always @(posedge comm_clock) cyc++;

    always @(negedge comm_clock) begin
        if (framing_error) fe_cnt++;
        if (overrun) ov_cnt++;
        if (busy) busy_run++;
        else busy_run = 0;
        if (busy_run > busy_max) busy_max = busy_run;
        if (valid && !valid_q) rise_cyc = cyc;
        valid_q = valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb);
        @(negedge comm_clock);
        rx_pin    = 1'b0;
        start_cyc = cyc;
        repeat (cpb) @(negedge comm_clock);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (cpb) @(negedge comm_clock);
        end
        rx_pin = stop_bit;
        repeat (cpb) @(negedge comm_clock);
        rx_pin = 1'b1;
    endtask

    task automatic handshake();
        @(negedge comm_clock);
        ready = 1'b1;
        @(negedge comm_clock);
        ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge comm_clock);
    endtask

    task automatic clear_counts();
        fe_cnt   = 0;
        ov_cnt   = 0;
        busy_max = 0;
    endtask

    initial begin
        int lat;
        reset          = 1'b1;
        rx_pin         = 1'b1;
        ready          = 1'b0;
        clocks_per_bit = 12'd16;
        idle(3);
        check_eq("rst_data_out", 32'(data_out), 32'h00);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_framing_error", 32'(framing_error), 32'h0);
        check_eq("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        idle(6);

        // cpb=16, 0xA5 with no consumer
        clear_counts();
        send_frame(8'hA5, 1'b1, 16);
        idle(4);
        lat = rise_cyc - start_cyc;
        check_eq("t1_data", 32'(data_out), 32'hA5);
        check_eq("t1_valid", 32'(valid), 32'h1);
        check_eq("t1_latency_in_152_156", 32'(lat >= 152 && lat <= 156), 32'h1);
        check_eq("t1_no_errors", 32'(fe_cnt + ov_cnt), 32'h0);
        idle(20);
        check_eq("t1_valid_held", 32'(valid), 32'h1);
        handshake();
        check_eq("t1_valid_drop", 32'(valid), 32'h0);
        check_eq("t1_data_held", 32'(data_out), 32'hA5);

        // cpb=16, 4-cycle glitch
        idle(4);
        clear_counts();
        @(negedge comm_clock);
        rx_pin = 1'b0;
        idle(4);
        rx_pin = 1'b1;
        idle(40);
        check_eq("t2_valid", 32'(valid), 32'h0);
        check_eq("t2_no_errors", 32'(fe_cnt + ov_cnt), 32'h0);
        check_eq("t2_busy_seen", 32'(busy_max >= 1), 32'h1);
        check_eq("t2_busy_len_le_10", 32'(busy_max <= 10), 32'h1);
        check_eq("t2_idle", 32'(busy), 32'h0);

        // cpb=10, bad stop bit then a clean frame
        clocks_per_bit = 12'd10;
        idle(4);
        clear_counts();
        send_frame(8'h3C, 1'b0, 10);
        idle(10);
        check_eq("t3_fe_one_cycle", 32'(fe_cnt), 32'h1);
        check_eq("t3_valid", 32'(valid), 32'h0);
        check_eq("t3_idle_after_break", 32'(busy), 32'h0);
        send_frame(8'h81, 1'b1, 10);
        idle(4);
        check_eq("t3_data", 32'(data_out), 32'h81);
        check_eq("t3_valid2", 32'(valid), 32'h1);
        check_eq("t3_fe_total", 32'(fe_cnt), 32'h1);
        handshake();

        // cpb=8, overrun
        clocks_per_bit = 12'd8;
        idle(4);
        clear_counts();
        send_frame(8'h11, 1'b1, 8);
        send_frame(8'h22, 1'b1, 8);
        idle(6);
        check_eq("t4_data_kept", 32'(data_out), 32'h11);
        check_eq("t4_valid", 32'(valid), 32'h1);
        check_eq("t4_overrun_once", 32'(ov_cnt), 32'h1);
        check_eq("t4_no_fe", 32'(fe_cnt), 32'h0);
        handshake();
        check_eq("t4_valid_drop", 32'(valid), 32'h0);

        // cpb=20, reset during data bit 4 of 0xFF
        clocks_per_bit = 12'd20;
        idle(4);
        clear_counts();
        fork
            send_frame(8'hFF, 1'b1, 20);
            begin
                idle(110);
                reset = 1'b1;
                idle(1);
                check_eq("t5_busy_in_reset", 32'(busy), 32'h0);
                check_eq("t5_data_in_reset", 32'(data_out), 32'h00);
                idle(2);
                reset = 1'b0;
            end
        join
        idle(10);
        check_eq("t5_data_out", 32'(data_out), 32'h00);
        check_eq("t5_valid", 32'(valid), 32'h0);
        check_eq("t5_busy", 32'(busy), 32'h0);
        check_eq("t5_no_pulses", 32'(fe_cnt + ov_cnt), 32'h0);
        send_frame(8'h5A, 1'b1, 20);
        idle(6);
        check_eq("t5_data_next", 32'(data_out), 32'h5A);
        check_eq("t5_valid_next", 32'(valid), 32'h1);
        handshake();

        // cpb below minimum, then at minimum
        clocks_per_bit = 12'd3;
        idle(4);
        clear_counts();
        send_frame(8'h55, 1'b1, 3);
        idle(10);
        check_eq("t6_busy_never", 32'(busy_max), 32'h0);
        check_eq("t6_valid", 32'(valid), 32'h0);
        check_eq("t6_no_pulses", 32'(fe_cnt + ov_cnt), 32'h0);
        clocks_per_bit = 12'd4;
        idle(4);
        send_frame(8'h55, 1'b1, 4);
        idle(6);
        check_eq("t6_data_min_cpb", 32'(data_out), 32'h55);
        check_eq("t6_valid_min_cpb", 32'(valid), 32'h1);
        check_eq("t6_no_fe_min_cpb", 32'(fe_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usart_rx.md
Name: usart_rx

Overview:
- Asynchronous serial receiver with 8N1 framing, LSB first; pairs with usart_tx in the USART library.
- Samples `rx_pin` with a programmable bit period counted in `comm_clock` cycles.
- Delivers received bytes to the bus side through a valid/ready handshake.
- Reports framing and overrun errors as single-cycle pulses.
- Single clock domain. Only `rx_pin` is asynchronous and is synchronised internally.

Parameters:
- SYNC_STAGES, 2, number of flops in the `rx_pin` synchroniser (legal values 2..3).

Ports:
- comm_clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clocks_per_bit  input  12  `comm_clock` cycles per serial bit. Must be stable while `busy`=1.
- rx_pin  input  1  serial line; idles high.
- data_out  output  8  received byte; valid while `valid`=1.
- valid  output  1  `data_out` holds an unconsumed byte.
- ready  input  1  consumer accepts `data_out` when `valid`&&`ready`.
- busy  output  1  frame reception in progress (state != IDLE).
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a frame completed while `valid`=1; the new byte is dropped.

Behaviour:
- Reset (asynchronous, on `reset`=1):
  - Outputs: `data_out`=0, `valid`=0, `busy`=0, `framing_error`=0, `overrun`=0.
  - Internal state: state=IDLE, counters=0, synchroniser flops=1 (line idle).
  - Mid-frame reset abandons the frame with no pulses. After release, a line that is still low is not treated as a start until it has been seen high (state BREAK_WAIT entered if synced rx=0).
- Synchroniser: SYNC_STAGES flops on `rx_pin`; `rx_s` = last stage. All decisions use `rx_s`.
- Bit counter `cnt` (12 bits). A "half" wait ends when `cnt`==(`clocks_per_bit`>>1)-1. A "full" wait ends when `cnt`==`clocks_per_bit`-1. `cnt` clears at each wait end.
- `clocks_per_bit` < 4: receiver stays in IDLE and ignores the line. `busy`=0.
- IDLE: on `rx_s`==0, go to START with `cnt`=0.
- START:
  - After a half wait, sample `rx_s`.
  - If 0: go to DATA, bit index=0.
  - If 1: glitch; return to IDLE with no pulse.
- DATA:
  - After each full wait, shift `rx_s` into shift register bit[index] (LSB first).
  - Advance to STOP after index 7.
- STOP: after a full wait, sample `rx_s`.
  - `rx_s`==1 and `valid`==0: `data_out`<=shift reg, `valid`<=1 in the same edge. Go to IDLE.
  - `rx_s`==1 and `valid`==1: `overrun` pulses 1 cycle. `data_out` and `valid` are unchanged. Go to IDLE.
  - `rx_s`==0: `framing_error` pulses 1 cycle, byte discarded. Go to BREAK_WAIT.
- BREAK_WAIT: remain until `rx_s`==1, then go to IDLE. This prevents a held-low line (break) from retriggering.
- Handshake:
  - `valid` falls on the edge after `valid`&&`ready`.
  - `data_out` holds its value until the next store.
  - If a completing frame stores on the same edge that a handshake completes (`valid`&&`ready` while the STOP sample is 1), the new byte is stored, `valid` stays 1, and no overrun is raised.
- Latency: `valid` rises between 9.5·cpb and 9.5·cpb+SYNC_STAGES+2 cycles after the start-bit falling edge on `rx_pin`.
- `busy`=1 in START, DATA, STOP and BREAK_WAIT.

Decomposition:
- Shared package `usart_pkg` holds:
  - state encodings (IDLE=0, START_BIT=1, DATA_BIT=2, STOP_BIT=3, BREAK_WAIT=4); the first four codes are shared with usart_tx;
  - `USART_DATA_BITS`=8;
  - `USART_MIN_CPB`=4.
- One sub-module, `usart_sync`: parameterised N-stage synchroniser with reset value 1. It is reusable for the CTS/RTS inputs later.

Test Plan:
- cpb=16, send 0xA5 (8N1); `ready` held 0 → `data_out`=0xA5, `valid` rises within cycles 152..156 after the start edge and stays 1. Then assert `ready` for 1 cycle → `valid`=0 next cycle.
- cpb=16, 4-cycle low glitch on `rx_pin` → returns to IDLE; no `valid`, no error pulse; `busy` high for ≤8+SYNC_STAGES cycles.
- cpb=10, send 0x3C with stop bit driven low, then line high → `framing_error` pulses exactly 1 cycle, `valid` stays 0. A following 0x81 frame is received correctly.
- cpb=8, send 0x11 then 0x22 back to back with `ready`=0 → `data_out`=0x11, `overrun` pulses once at the second stop sample, `data_out` still 0x11.
- cpb=20, assert `reset` during data bit 4 of 0xFF, release with line high → all outputs 0. The next frame 0x5A is received correctly.
- cpb=3, send 0x55 → `busy` never asserts, `valid` stays 0. Then cpb=4, send 0x55 → `data_out`=0x55.
